// File: rtl/fpu_ss_wb_arbiter.sv
// Write-back arbiter: merges FPU results and load returns into a single registered
// result slot that feeds the CV-X-IF result channel and the FP register file.
package fpu_ss_wb_pkg;
  localparam int unsigned X_ID_W   = 4;
  localparam int unsigned X_DATA_W = 32;

  typedef struct packed {
    logic [X_ID_W-1:0]   id;
    logic [X_DATA_W-1:0] data;
    logic [4:0]          rd;
    logic                we;
    logic [2:0]          ecswe;
    logic [5:0]          ecsdata;
    logic                exc;
    logic [5:0]          exccode;
    logic                dbg;
    logic                err;
  } x_result_t;
endpackage

module fpu_ss_wb_arbiter
  import fpu_ss_wb_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned FLEN       = 32,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [9:0]      fpu_tag_i,
  input  logic [4:0]      fpu_status_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [31:0]     mem_rdata_i,
  input  logic [9:0]      mem_meta_i,
  input  logic            mem_err_i,
  output logic            x_result_valid_o,
  input  logic            x_result_ready_i,
  output x_result_t       x_result_o,
  output logic            fpr_we_o,
  output logic [4:0]      fpr_waddr_o,
  output logic [FLEN-1:0] fpr_wdata_o,
  output logic            fflags_we_o,
  output logic [4:0]      fflags_o,
  output logic            busy_o
);

  localparam int unsigned DATA_W = (FLEN > XLEN) ? FLEN : XLEN;

  typedef enum logic {SRC_FPU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic                  slot_valid_q, slot_valid_d;
  src_e                  rr_q, rr_d;
  src_e                  src_q, src_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rd_is_fp_q, rd_is_fp_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [4:0]            fflags_q, fflags_d;

  logic load_en_c, gnt_fpu_c, gnt_mem_c, retire_c;
  logic [XLEN-1:0] xdata_c;
  logic unused_meta_we;

  assign unused_meta_we = mem_meta_i[0];

  // Slot refills whenever it is empty or retiring this cycle; rr breaks ties.
  always_comb begin
    load_en_c    = !slot_valid_q | x_result_ready_i;
    gnt_fpu_c    = fpu_valid_i & (!mem_valid_i | (rr_q == SRC_FPU));
    gnt_mem_c    = mem_valid_i & (!fpu_valid_i | (rr_q == SRC_MEM));
    slot_valid_d = slot_valid_q;
    rr_d         = rr_q;
    src_d        = src_q;
    id_d         = id_q;
    data_d       = data_q;
    rd_d         = rd_q;
    rd_is_fp_d   = rd_is_fp_q;
    we_d         = we_q;
    err_d        = err_q;
    fflags_d     = fflags_q;
    if (load_en_c) begin
      slot_valid_d = gnt_fpu_c | gnt_mem_c;
      if (fpu_valid_i & mem_valid_i) rr_d = gnt_fpu_c ? SRC_MEM : SRC_FPU;
      if (gnt_fpu_c) begin
        src_d      = SRC_FPU;
        id_d       = X_ID_WIDTH'(fpu_tag_i[3:0]);
        data_d     = DATA_W'(fpu_result_i);
        rd_d       = fpu_tag_i[9:5];
        rd_is_fp_d = fpu_tag_i[4];
        we_d       = !fpu_tag_i[4];
        err_d      = 1'b0;
        fflags_d   = fpu_status_i;
      end else if (gnt_mem_c) begin
        src_d      = SRC_MEM;
        id_d       = X_ID_WIDTH'(mem_meta_i[9:6]);
        data_d     = DATA_W'(mem_rdata_i);
        rd_d       = mem_meta_i[5:1];
        rd_is_fp_d = 1'b1;
        we_d       = 1'b0;
        err_d      = mem_err_i;
        fflags_d   = 5'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= 1'b0;
      rr_q         <= SRC_FPU;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_q         <= rr_d;
    end
  end

  // Payload is qualified by slot_valid_q and needs no reset.
  always_ff @(posedge clk_i) begin
    src_q      <= src_d;
    id_q       <= id_d;
    data_q     <= data_d;
    rd_q       <= rd_d;
    rd_is_fp_q <= rd_is_fp_d;
    we_q       <= we_d;
    err_q      <= err_d;
    fflags_q   <= fflags_d;
  end

  // rst_i gating keeps handshakes and writes quiet during the reset cycle itself.
  assign retire_c         = slot_valid_q & x_result_ready_i & !rst_i;
  assign fpu_ready_o      = load_en_c & gnt_fpu_c & !rst_i;
  assign mem_ready_o      = load_en_c & gnt_mem_c & !rst_i;
  assign x_result_valid_o = slot_valid_q & !rst_i;
  assign busy_o           = slot_valid_q & !rst_i;
  assign fpr_we_o         = retire_c & rd_is_fp_q & !err_q;
  assign fpr_waddr_o      = rd_q;
  assign fpr_wdata_o      = FLEN'(data_q);
  assign fflags_we_o      = retire_c & (src_q == SRC_FPU);
  assign fflags_o         = fflags_q;
  assign xdata_c          = XLEN'(data_q);

  always_comb begin
    x_result_o      = '0;
    x_result_o.id   = X_ID_W'(id_q);
    x_result_o.data = X_DATA_W'(xdata_c);
    x_result_o.rd   = rd_q;
    x_result_o.we   = we_q;
    x_result_o.err  = err_q;
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter: reset, FPU/load capture, round-robin,
// back-pressure, load errors and reset while a result is held.
module tb_fpu_ss_wb_arbiter;
  import fpu_ss_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, fv, mv, merr, xrdy;
  logic [31:0] fres, mrd;
  logic [9:0]  ftag, mmeta;
  logic [4:0]  fst;
  logic        fpu_rdy, mem_rdy, xval, fpr_we, ffw, busy;
  logic [4:0]  fpr_waddr, ff;
  logic [31:0] fpr_wdata;
  x_result_t   xres;
  int          checks = 0;
  int          errors = 0;
  logic        exp_f;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter #(.X_ID_WIDTH(4), .FLEN(32), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .fpu_valid_i(fv), .fpu_ready_o(fpu_rdy), .fpu_result_i(fres),
    .fpu_tag_i(ftag), .fpu_status_i(fst),
    .mem_valid_i(mv), .mem_ready_o(mem_rdy), .mem_rdata_i(mrd),
    .mem_meta_i(mmeta), .mem_err_i(merr),
    .x_result_valid_o(xval), .x_result_ready_i(xrdy), .x_result_o(xres),
    .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr), .fpr_wdata_o(fpr_wdata),
    .fflags_we_o(ffw), .fflags_o(ff), .busy_o(busy)
  );

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic test_reset();
    rst = 1; fv = 1; mv = 1; xrdy = 1; merr = 0;
    fres = 32'h0; ftag = 10'h0; fst = 5'h0; mrd = 32'h0; mmeta = 10'h0;
    step(); smp();
    checks++; if (xval !== 1'b0)    begin errors++; $display("FAIL rst_xval got %0h exp 0", xval); end
    checks++; if (fpu_rdy !== 1'b0) begin errors++; $display("FAIL rst_fpu_ready got %0h exp 0", fpu_rdy); end
    checks++; if (mem_rdy !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %0h exp 0", mem_rdy); end
    checks++; if (fpr_we !== 1'b0)  begin errors++; $display("FAIL rst_fpr_we got %0h exp 0", fpr_we); end
    checks++; if (ffw !== 1'b0)     begin errors++; $display("FAIL rst_fflags_we got %0h exp 0", ffw); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
    step();
    rst = 0; fv = 0; mv = 0; xrdy = 0;
    smp();
    checks++; if (xval !== 1'b0) begin errors++; $display("FAIL post_rst_xval got %0h exp 0", xval); end
    step();
  endtask

  task automatic test_fpu_fp_write();
    fv = 1; ftag = {5'd5, 1'b1, 4'd3}; fres = 32'h3F800000; fst = 5'h01; xrdy = 1;
    smp();
    checks++; if (fpu_rdy !== 1'b1) begin errors++; $display("FAIL fp_fpu_ready got %0h exp 1", fpu_rdy); end
    checks++; if (mem_rdy !== 1'b0) begin errors++; $display("FAIL fp_mem_ready got %0h exp 0", mem_rdy); end
    step(); fv = 0; smp();
    checks++; if (xval !== 1'b1)             begin errors++; $display("FAIL fp_xval got %0h exp 1", xval); end
    checks++; if (xres.id !== 4'd3)          begin errors++; $display("FAIL fp_id got %0h exp 3", xres.id); end
    checks++; if (xres.we !== 1'b0)          begin errors++; $display("FAIL fp_we got %0h exp 0", xres.we); end
    checks++; if (fpr_we !== 1'b1)           begin errors++; $display("FAIL fp_fpr_we got %0h exp 1", fpr_we); end
    checks++; if (fpr_waddr !== 5'd5)        begin errors++; $display("FAIL fp_waddr got %0h exp 5", fpr_waddr); end
    checks++; if (fpr_wdata !== 32'h3F800000) begin errors++; $display("FAIL fp_wdata got %0h exp 3f800000", fpr_wdata); end
    checks++; if (ffw !== 1'b1)              begin errors++; $display("FAIL fp_fflags_we got %0h exp 1", ffw); end
    checks++; if (ff !== 5'h01)              begin errors++; $display("FAIL fp_fflags got %0h exp 1", ff); end
    step(); smp();
    checks++; if (xval !== 1'b0) begin errors++; $display("FAIL fp_drain_xval got %0h exp 0", xval); end
    step();
  endtask

  task automatic test_fpu_int_result();
    fv = 1; ftag = {5'd10, 1'b0, 4'd7}; fres = 32'h00000002; fst = 5'h00; xrdy = 1;
    step(); fv = 0; smp();
    checks++; if (xval !== 1'b1)         begin errors++; $display("FAIL int_xval got %0h exp 1", xval); end
    checks++; if (xres.we !== 1'b1)      begin errors++; $display("FAIL int_we got %0h exp 1", xres.we); end
    checks++; if (xres.rd !== 5'd10)     begin errors++; $display("FAIL int_rd got %0h exp a", xres.rd); end
    checks++; if (xres.id !== 4'd7)      begin errors++; $display("FAIL int_id got %0h exp 7", xres.id); end
    checks++; if (xres.data !== 32'd2)   begin errors++; $display("FAIL int_data got %0h exp 2", xres.data); end
    checks++; if (fpr_we !== 1'b0)       begin errors++; $display("FAIL int_fpr_we got %0h exp 0", fpr_we); end
    checks++; if (ffw !== 1'b1)          begin errors++; $display("FAIL int_fflags_we got %0h exp 1", ffw); end
    step();
  endtask

  task automatic test_back_to_back();
    rst = 1; fv = 0; mv = 0; xrdy = 0;
    step();
    rst = 0; xrdy = 1; merr = 0;
    fv = 1; ftag = {5'd1, 1'b1, 4'd1}; fres = 32'h11111111; fst = 5'h02;
    mv = 1; mmeta = {4'd2, 5'd6, 1'b1}; mrd = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      smp();
      exp_f = (i % 2 == 0);
      checks++; if (fpu_rdy !== exp_f)  begin errors++; $display("FAIL b2b_fpu_ready[%0d] got %0h exp %0h", i, fpu_rdy, exp_f); end
      checks++; if (mem_rdy !== !exp_f) begin errors++; $display("FAIL b2b_mem_ready[%0d] got %0h exp %0h", i, mem_rdy, !exp_f); end
      if (i > 0) begin
        checks++;
        if (xval !== 1'b1 || xres.id !== (exp_f ? 4'd2 : 4'd1)) begin
          errors++; $display("FAIL b2b_result[%0d] got valid=%0h id=%0h exp valid=1 id=%0h", i, xval, xres.id, exp_f ? 4'd2 : 4'd1);
        end
      end
      step();
    end
    fv = 0; mv = 0;
    smp();
    checks++; if (xval !== 1'b1 || xres.id !== 4'd2) begin errors++; $display("FAIL b2b_last got valid=%0h id=%0h exp valid=1 id=2", xval, xres.id); end
    checks++; if (xres.we !== 1'b0)           begin errors++; $display("FAIL b2b_load_we got %0h exp 0", xres.we); end
    checks++; if (fpr_we !== 1'b1 || fpr_waddr !== 5'd6 || fpr_wdata !== 32'h22222222) begin
      errors++; $display("FAIL b2b_load_fpr got we=%0h addr=%0h data=%0h exp 1/6/22222222", fpr_we, fpr_waddr, fpr_wdata);
    end
    checks++; if (ffw !== 1'b0) begin errors++; $display("FAIL b2b_load_fflags_we got %0h exp 0", ffw); end
    step(); smp();
    checks++; if (xval !== 1'b0) begin errors++; $display("FAIL b2b_drain_xval got %0h exp 0", xval); end
    step();
  endtask

  task automatic test_backpressure();
    fv = 1; ftag = {5'd3, 1'b1, 4'd5}; fres = 32'hAAAA0000; fst = 5'h04;
    mv = 1; mmeta = {4'd9, 5'd7, 1'b0}; mrd = 32'hBBBB0000; merr = 0; xrdy = 1;
    smp();
    checks++; if (fpu_rdy !== 1'b1) begin errors++; $display("FAIL bp_first_grant got %0h exp 1", fpu_rdy); end
    step(); xrdy = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++; if (fpu_rdy !== 1'b0 || mem_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got fpu=%0h mem=%0h exp 0/0", i, fpu_rdy, mem_rdy); end
      checks++; if (xval !== 1'b1 || xres.id !== 4'd5 || xres.data !== 32'hAAAA0000) begin
        errors++; $display("FAIL bp_hold[%0d] got valid=%0h id=%0h data=%0h exp 1/5/aaaa0000", i, xval, xres.id, xres.data);
      end
      checks++; if (fpr_we !== 1'b0 || ffw !== 1'b0) begin errors++; $display("FAIL bp_writes[%0d] got fpr_we=%0h fflags_we=%0h exp 0/0", i, fpr_we, ffw); end
      step();
    end
    xrdy = 1;
    smp();
    checks++; if (fpr_we !== 1'b1 || ffw !== 1'b1 || ff !== 5'h04) begin
      errors++; $display("FAIL bp_retire got fpr_we=%0h fflags_we=%0h fflags=%0h exp 1/1/4", fpr_we, ffw, ff);
    end
    checks++; if (mem_rdy !== 1'b1 || fpu_rdy !== 1'b0) begin errors++; $display("FAIL bp_regrant got fpu=%0h mem=%0h exp 0/1", fpu_rdy, mem_rdy); end
    step(); fv = 0; mv = 0; smp();
    checks++; if (xval !== 1'b1 || xres.id !== 4'd9 || xres.data !== 32'hBBBB0000) begin
      errors++; $display("FAIL bp_load got valid=%0h id=%0h data=%0h exp 1/9/bbbb0000", xval, xres.id, xres.data);
    end
    checks++; if (fpr_waddr !== 5'd7 || ffw !== 1'b0) begin errors++; $display("FAIL bp_load_wb got addr=%0h fflags_we=%0h exp 7/0", fpr_waddr, ffw); end
    step();
  endtask

  task automatic test_load_error();
    mv = 1; mmeta = {4'd2, 5'd4, 1'b0}; mrd = 32'hDEADBEEF; merr = 1; xrdy = 1;
    smp();
    checks++; if (mem_rdy !== 1'b1 || fpu_rdy !== 1'b0) begin errors++; $display("FAIL lerr_ready got fpu=%0h mem=%0h exp 0/1", fpu_rdy, mem_rdy); end
    step(); mv = 0; merr = 0; smp();
    checks++; if (xval !== 1'b1 || xres.err !== 1'b1 || xres.id !== 4'd2 || xres.rd !== 5'd4) begin
      errors++; $display("FAIL lerr_result got valid=%0h err=%0h id=%0h rd=%0h exp 1/1/2/4", xval, xres.err, xres.id, xres.rd);
    end
    checks++; if (fpr_we !== 1'b0 || ffw !== 1'b0) begin errors++; $display("FAIL lerr_writes got fpr_we=%0h fflags_we=%0h exp 0/0", fpr_we, ffw); end
    step();
  endtask

  task automatic test_reset_mid_op();
    fv = 1; ftag = {5'd8, 1'b1, 4'd1}; fres = 32'h12345678; fst = 5'h10;
    mv = 1; mmeta = {4'd3, 5'd9, 1'b0}; mrd = 32'h0; merr = 0; xrdy = 1;
    smp();
    checks++; if (fpu_rdy !== 1'b1) begin errors++; $display("FAIL rmid_grant got %0h exp 1", fpu_rdy); end
    step(); rst = 1; xrdy = 0; smp();
    checks++; if (xval !== 1'b0 || fpu_rdy !== 1'b0 || mem_rdy !== 1'b0 || fpr_we !== 1'b0 || ffw !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_under_rst got val=%0h fr=%0h mr=%0h fwe=%0h ffw=%0h busy=%0h exp all 0", xval, fpu_rdy, mem_rdy, fpr_we, ffw, busy);
    end
    step(); rst = 0; xrdy = 1; smp();
    checks++; if (xval !== 1'b0 || fpr_we !== 1'b0 || ffw !== 1'b0) begin
      errors++; $display("FAIL rmid_dropped got val=%0h fwe=%0h ffw=%0h exp 0/0/0", xval, fpr_we, ffw);
    end
    checks++; if (fpu_rdy !== 1'b1 || mem_rdy !== 1'b0) begin errors++; $display("FAIL rmid_rr got fpu=%0h mem=%0h exp 1/0", fpu_rdy, mem_rdy); end
    step(); fv = 0; mv = 0; step(); step();
  endtask

  initial begin
    test_reset();
    test_fpu_fp_write();
    test_fpu_int_result();
    test_back_to_back();
    test_backpressure();
    test_load_error();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_ss_wb_arbiter.md
FPU_SS_WB_ARBITER -- requirements
Module: fpu_ss_wb_arbiter

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, offloaded-instruction id width.
REQ-002 SHALL have parameter FLEN, default 32, FP register width.
REQ-003 SHALL have parameter XLEN, default 32, integer result width.
REQ-004 SHALL have port clk_i  input  1  the single clock.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fpu_valid_i  input  1  FPU result valid.
REQ-007 SHALL have port fpu_ready_o  output  1  FPU result accepted this cycle.
REQ-008 SHALL have port fpu_result_i  input  FLEN  FPU result data.
REQ-009 SHALL have port fpu_tag_i  input  10  FPU tag {addr[4:0], rd_is_fp, id[3:0]}.
REQ-010 SHALL have port fpu_status_i  input  5  FPU fflags {NV,DZ,OF,UF,NX}.
REQ-011 SHALL have port mem_valid_i  input  1  load result valid.
REQ-012 SHALL have port mem_ready_o  output  1  load result accepted this cycle.
REQ-013 SHALL have port mem_rdata_i  input  32  load data.
REQ-014 SHALL have port mem_meta_i  input  10  load metadata {id[3:0], rd[4:0], we}.
REQ-015 SHALL have port mem_err_i  input  1  load bus error.
REQ-016 SHALL have port x_result_valid_o  output  1  CV-X-IF result valid.
REQ-017 SHALL have port x_result_ready_i  input  1  core ready for result.
REQ-018 SHALL have port x_result_o  output  struct  {id, data[XLEN], rd[5], we, err}; ecs/exc/dbg fields tied 0.
REQ-019 SHALL have port fpr_we_o  output  1  FP regfile write enable.
REQ-020 SHALL have port fpr_waddr_o  output  5  FP regfile write address.
REQ-021 SHALL have port fpr_wdata_o  output  FLEN  FP regfile write data.
REQ-022 SHALL have port fflags_we_o  output  1  fflags accumulate enable.
REQ-023 SHALL have port fflags_o  output  5  fflags to OR into fcsr.
REQ-024 SHALL have port busy_o  output  1  result slot occupied.

Function
REQ-025 SHALL hold one registered result slot: {valid, src, id, data, rd, rd_is_fp, we, err, fflags}.
REQ-026 slot load enable SHALL be load_en = !slot_valid | (x_result_valid_o & x_result_ready_i); zero bubble on back-to-back.
REQ-027 Arbitration, both valid and load_en: grant side named by rr pointer; rr pointer reset value = FPU.
REQ-028 After every grant with both sources valid, rr SHALL point to the non-granted side; single-requester grants SHALL leave rr unchanged.
REQ-029 Exactly one valid: that source SHALL be granted when load_en.
REQ-030 fpu_ready_o / mem_ready_o SHALL be combinational (load_en & grant); never both 1 in a cycle.
REQ-031 fpu_ready_o SHALL not depend on fpu_valid_i except via arbitration; no combinational path x_result_ready_i -> x_result_valid_o.
REQ-032 FPU capture: id = tag.id, rd = tag.addr, rd_is_fp = tag.rd_is_fp, data = fpu_result_i, x we = !rd_is_fp, err = 0, fflags = fpu_status_i.
REQ-033 Load capture: id = meta.id, rd = meta.rd, rd_is_fp = 1, data = mem_rdata_i, x we = 0, err = mem_err_i, fflags = 0.
REQ-034 x_result_valid_o SHALL equal slot_valid; x_result_o fields driven from slot, stable while valid & !ready.
REQ-035 Retire = x_result_valid_o & x_result_ready_i; fpr_we_o SHALL be retire & rd_is_fp & !err (combinational), addr/data from slot.
REQ-036 fflags_we_o SHALL be retire & src==FPU; fflags_o = slot fflags.
REQ-037 Latency: source accept to x_result_valid_o = 1 cycle; FP regfile write in the retire cycle.
REQ-038 Slot valid & !x_result_ready_i: both readys 0, slot held, no regfile/fflags write.
REQ-039 busy_o SHALL equal slot_valid.

Reset
REQ-040 rst_i high at clk_i edge SHALL clear slot_valid and set rr = FPU; slot payload need not reset.
REQ-041 Under reset: x_result_valid_o, fpu_ready_o, mem_ready_o, fpr_we_o, fflags_we_o, busy_o SHALL all be 0.
REQ-042 Reset mid-operation SHALL drop any held result without a regfile or fflags write; first post-reset cycle SHALL show ready = 1 for a valid source.

Verification
REQ-043 FPU only, tag {addr=5, rd_is_fp=1, id=3}, result 0x3F800000, status 0x01, ready_i=1 -> next cycle x_result id=3 we=0; fpr_we=1 addr=5 data=0x3F800000; fflags_we=1 fflags=0x01.
REQ-044 FPU fcvt.w.s, tag rd_is_fp=0 addr=10 id=7, result 0x00000002 -> x_result we=1 rd=10 data=2; fpr_we=0.
REQ-045 Both valid continuously 4 cycles after reset, ready_i=1 -> grants FPU, MEM, FPU, MEM; x_result valid every cycle from cycle 1.
REQ-046 Slot full, ready_i=0 for 3 cycles, both sources valid -> both readys 0, x_result stable, no fpr_we/fflags_we; ready_i=1 -> retire and new capture same cycle.
REQ-047 Load with mem_err_i=1, id=2 rd=4 -> x_result err=1 id=2; fpr_we=0.
REQ-048 rst_i asserted while slot valid & ready_i=0 -> next cycle x_result_valid_o=0, no regfile write, rr = FPU.
